// File: rtl/stream_token_pkg.sv
// Shared token definitions for the sparse stream source/sink pair.
// Pure declarations: no state, no latency, no flow control.
package stream_token_pkg;

  localparam int TOKEN_W = 17;

  typedef enum logic [1:0] {
    CT_STOP = 2'b00,
    CT_DONE = 2'b01
  } ctrl_type_e;

  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_e;

  function automatic logic is_ctrl(input logic [TOKEN_W-1:0] tok);
    return tok[16];
  endfunction

  function automatic logic is_stop(input logic [TOKEN_W-1:0] tok);
    return tok[16] && (tok[9:8] == CT_STOP);
  endfunction

  function automatic logic is_done(input logic [TOKEN_W-1:0] tok);
    return tok[16] && (tok[9:8] == CT_DONE);
  endfunction

  function automatic logic [7:0] stop_lvl(input logic [TOKEN_W-1:0] tok);
    return tok[7:0];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Seedable 16-bit Fibonacci LFSR (taps 16,14,13,11), reloaded by flush.
// Advances one step per enabled cycle; no flow control.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        en,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (flush) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

endmodule

// File: rtl/stream_token_sink.sv
// Terminating sink for the sparse token stream: decodes, counts and checks handshakes.
// Zero-latency accept; counters update one cycle after accept; ready gated by LFSR when bp_en.
module stream_token_sink
  import stream_token_pkg::*;
#(
  parameter int          TX_NUM    = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               bp_en,
  input  logic [16:0]        data,
  input  logic               valid,
  output logic               ready,
  output logic               done,
  output logic [CNT_W-1:0]   data_count,
  output logic [CNT_W-1:0]   stop_count,
  output logic [15:0]        tx_count,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [7:0]         max_stop_lvl,
  output logic               proto_err
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [15:0]      TX_TARGET = 16'(TX_NUM);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0]   stop_cnt_q, stop_cnt_d;
  logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [15:0]        tx_cnt_q, tx_cnt_d;
  logic [7:0]         lvl_q, lvl_d;
  logic               err_q, err_d;
  logic               stall_q;
  logic [TOKEN_W-1:0] held_q;
  logic [15:0]        lfsr;
  logic               unused_lfsr_hi;
  logic               accept;
  logic               tok_data, tok_stop, tok_done, tok_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .en    (1'b1),
    .lfsr  (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:2];

  assign ready    = (state_q != ST_DONE) && (!bp_en || (lfsr[1:0] != 2'b00));
  assign accept   = valid && ready;
  assign tok_data = !is_ctrl(data);
  assign tok_stop = is_stop(data);
  assign tok_done = is_done(data);
  assign tok_bad  = is_ctrl(data) && !tok_stop && !tok_done;

  always_comb begin
    state_d    = state_q;
    data_cnt_d = data_cnt_q;
    stop_cnt_d = stop_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    lvl_d      = lvl_q;
    err_d      = err_q;

    if (valid && (state_q == ST_DONE)) err_d = 1'b1;
    // A stalled token must be re-presented unchanged on the following cycle.
    if (stall_q && (!valid || (data != held_q))) err_d = 1'b1;
    if (accept && tok_bad) err_d = 1'b1;

    if (state_q == ST_ACTIVE) cyc_cnt_d = sat_inc(cyc_cnt_q);

    if (accept) begin
      // Totals of the previous transaction stay visible until the next one starts.
      if (state_q == ST_IDLE) begin
        data_cnt_d = '0;
        stop_cnt_d = '0;
        lvl_d      = '0;
        cyc_cnt_d  = CNT_ONE;
        state_d    = ST_ACTIVE;
      end
      if (tok_data) data_cnt_d = sat_inc(data_cnt_d);
      if (tok_stop) begin
        stop_cnt_d = sat_inc(stop_cnt_d);
        if (stop_lvl(data) > lvl_d) lvl_d = stop_lvl(data);
      end
      if (tok_done) begin
        tx_cnt_d = (&tx_cnt_q) ? tx_cnt_q : tx_cnt_q + 16'd1;
        state_d  = (tx_cnt_d == TX_TARGET) ? ST_DONE : ST_IDLE;
      end
    end

    if (flush) begin
      state_d    = ST_IDLE;
      data_cnt_d = '0;
      stop_cnt_d = '0;
      cyc_cnt_d  = '0;
      tx_cnt_d   = '0;
      lvl_d      = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_cnt_q <= '0;
      stop_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      tx_cnt_q   <= '0;
      lvl_q      <= '0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
      held_q     <= '0;
    end else begin
      state_q    <= state_d;
      data_cnt_q <= data_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      lvl_q      <= lvl_d;
      err_q      <= err_d;
      stall_q    <= flush ? 1'b0 : (valid && !ready);
      held_q     <= data;
    end
  end

  assign done         = (state_q == ST_DONE);
  assign data_count   = data_cnt_q;
  assign stop_count   = stop_cnt_q;
  assign tx_count     = tx_cnt_q;
  assign cycle_count  = cyc_cnt_q;
  assign max_stop_lvl = lvl_q;
  assign proto_err    = err_q;

endmodule

// File: tb/tb_stream_token_sink.sv
// Bench for stream_token_sink: directed scenarios plus random traffic against a behavioural model.
module tb_stream_token_sink;
  import stream_token_pkg::*;

  localparam int TXN = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush, bp_en, valid;
  logic [16:0] data;
  logic        ready, done, proto_err;
  logic [31:0] data_count, stop_count, cycle_count;
  logic [15:0] tx_count;
  logic [7:0]  max_stop_lvl;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  stream_token_sink #(.TX_NUM(TXN), .LFSR_SEED(16'hACE1), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bp_en        (bp_en),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .done         (done),
    .data_count   (data_count),
    .stop_count   (stop_count),
    .tx_count     (tx_count),
    .cycle_count  (cycle_count),
    .max_stop_lvl (max_stop_lvl),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_lfsr;
  bit          m_in_tx, m_fin, m_err, m_pstall, m_r, m_acc;
  logic [16:0] m_pdata;
  longint      m_dc, m_sc, m_cyc, m_tx, m_lvl;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic bit m_ready();
    return !m_fin && (!bp_en || (m_lfsr[1:0] != 2'b00));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      m_lfsr = 16'hACE1; m_in_tx = 0; m_fin = 0; m_err = 0; m_pstall = 0; m_pdata = '0;
      m_dc = 0; m_sc = 0; m_cyc = 0; m_tx = 0; m_lvl = 0;
    end else begin
      m_r   = m_ready();
      m_acc = valid && m_r;
      if (m_pstall && (!valid || data !== m_pdata)) m_err = 1;
      if (valid && m_fin) m_err = 1;
      if (m_acc && !m_in_tx) begin
        m_in_tx = 1; m_dc = 0; m_sc = 0; m_lvl = 0; m_cyc = 0;
      end
      if (m_in_tx) m_cyc++;
      if (m_acc) begin
        if (!data[16]) m_dc++;
        else if (data[9:8] == 2'b00) begin
          m_sc++;
          if (longint'(data[7:0]) > m_lvl) m_lvl = data[7:0];
        end else if (data[9:8] == 2'b01) begin
          m_tx++;
          m_in_tx = 0;
          if (m_tx == TXN) m_fin = 1;
        end else m_err = 1;
      end
      m_pstall = valid && !m_r;
      m_pdata  = data;
      m_lfsr   = lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", ready, m_ready());
      chk("done", done, m_fin);
      chk("data_count", data_count, m_dc);
      chk("stop_count", stop_count, m_sc);
      chk("tx_count", tx_count, m_tx);
      chk("cycle_count", cycle_count, m_cyc);
      chk("max_stop_lvl", max_stop_lvl, m_lvl);
      chk("proto_err", proto_err, m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [16:0] tok, output int edge_no);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    valid = 1'b1;
    data  = tok;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      n++;
    end
    edge_no = cyc_n;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: token %h not accepted, got ready=0 for %0d cycles, expected acceptance", tok, n);
    end
  endtask

  task automatic do_flush();
    valid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic find_stall(output bit found);
    found = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!ready) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL find_stall: got no ready=0 cycle in 64, expected one");
    end
  endtask

  logic [16:0] stream_s [6];
  int first_e, last_e, e;
  bit found;
  logic [16:0] tok;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stream_s = '{17'h00005, 17'h00007, 17'h10000, 17'h00009, 17'h10001, DONE_TOKEN};
    rst_n = 1'b0; flush = 1'b0; bp_en = 1'b0; valid = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_data_count", data_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_tx_count", tx_count, 0);
    chk("rel_cycle_count", cycle_count, 0);
    chk("rel_proto_err", proto_err, 0);

    // Back-to-back transaction, no backpressure
    @(posedge clk); #1;
    foreach (stream_s[i]) begin
      send(stream_s[i], e);
      if (i == 0) first_e = e;
      last_e = e;
    end
    valid = 1'b0;
    chk("a_b2b_edges", last_e - first_e + 1, 6);
    @(negedge clk);
    chk("a_data_count", data_count, 3);
    chk("a_stop_count", stop_count, 2);
    chk("a_max_lvl", max_stop_lvl, 1);
    chk("a_cycle_count", cycle_count, 6);
    chk("a_tx_count", tx_count, 1);
    chk("a_done", done, 0);
    repeat (10) @(negedge clk);
    chk("gap_data_count", data_count, 3);
    chk("gap_cycle_count", cycle_count, 6);

    // Same stream with backpressure; source holds while stalled
    @(posedge clk); #1;
    bp_en = 1'b1;
    foreach (stream_s[i]) begin
      send(stream_s[i], e);
      if (i == 0) begin
        first_e = e;
        chk("b_restart_data", data_count, 1);
        chk("b_restart_tx", tx_count, 1);
      end
      last_e = e;
    end
    valid = 1'b0;
    @(negedge clk);
    chk("b_data_count", data_count, 3);
    chk("b_stop_count", stop_count, 2);
    chk("b_max_lvl", max_stop_lvl, 1);
    chk("b_cycle_count", cycle_count, last_e - first_e + 1);
    chk("b_tx_count", tx_count, 2);
    chk("b_done", done, 1);
    chk("b_ready", ready, 0);
    chk("b_proto_err", proto_err, 0);

    // valid while DONE
    @(posedge clk); #1;
    valid = 1'b1; data = 17'h5;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("done_valid_err", proto_err, 1);
    chk("done_held", done, 1);

    // Flush out of DONE, then flush mid-transaction
    @(posedge clk); #1;
    do_flush();
    bp_en = 1'b0;
    @(negedge clk);
    chk("f_done", done, 0);
    chk("f_tx_count", tx_count, 0);
    chk("f_proto_err", proto_err, 0);
    @(posedge clk); #1;
    send(17'h00005, e); send(17'h10003, e); send(17'h00006, e);
    do_flush();
    @(negedge clk);
    chk("fm_data_count", data_count, 0);
    chk("fm_stop_count", stop_count, 0);
    chk("fm_cycle_count", cycle_count, 0);
    @(posedge clk); #1;
    send(17'h00008, e); send(DONE_TOKEN, e);
    valid = 1'b0;
    @(negedge clk);
    chk("fm2_data_count", data_count, 1);
    chk("fm2_cycle_count", cycle_count, 2);
    chk("fm2_tx_count", tx_count, 1);

    // Reserved control class
    @(posedge clk); #1;
    send(17'h00005, e); send(17'h10200, e);
    valid = 1'b0;
    @(negedge clk);
    chk("bad_ctrl_err", proto_err, 1);
    chk("bad_ctrl_data", data_count, 1);
    chk("bad_ctrl_stop", stop_count, 0);

    // Data changed while stalled
    @(posedge clk); #1;
    do_flush();
    bp_en = 1'b1; valid = 1'b1; data = 17'h3;
    find_stall(found);
    @(posedge clk); #1;
    data = 17'h4;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("hs_data_err", proto_err, 1);
    repeat (5) @(negedge clk);
    chk("hs_data_sticky", proto_err, 1);
    @(posedge clk); #1;
    do_flush();
    @(negedge clk);
    chk("hs_flush_clear", proto_err, 0);

    // valid dropped while stalled
    @(posedge clk); #1;
    valid = 1'b1; data = 17'h3;
    find_stall(found);
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hs_drop_err", proto_err, 1);

    // Random compliant traffic
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #1;
      do_flush();
      bp_en = 1'($urandom_range(0, 1));
      for (int k = 0; k < 300 && !m_fin; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          valid = 1'b0;
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1;
        end
        case ($urandom_range(0, 9))
          0:       tok = DONE_TOKEN;
          1, 2, 3: tok = {9'h100, 8'($urandom_range(0, 255))};
          default: tok = {1'b0, 16'($urandom)};
        endcase
        send(tok, e);
      end
      valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_token_sink.md
# stream_token_sink

Synthesizable receiver for the sparse token stream that the fiber-access and scanner tiles emit on their ready/valid outputs. It accepts 17-bit tokens and decodes them into data, stop and done classes. It applies programmable pseudo-random backpressure, counts tokens and cycles per transaction, and checks the handshake contract. It sits at a tile output port in unit-test harnesses and on-chip self-test paths, terminating the same stream that the GLB-side stream source drives into a tile.

## Interface
Parameters:
- `TX_NUM`, 1: number of transactions (done tokens) to accept before asserting `done`.
- `LFSR_SEED`, 16'hACE1: reset/flush value of the backpressure LFSR; must be nonzero.
- `CNT_W`, 32: width of all counters.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear to reset state (LFSR reloaded).
- `bp_en`  in  1  enable pseudo-random backpressure.
- `data`  in  17  token; bit 16 = control flag.
- `valid`  in  1  token valid.
- `ready`  out  1  sink can accept.
- `done`  out  1  `TX_NUM` done tokens accepted.
- `data_count`  out  `CNT_W`  data tokens accepted, current transaction.
- `stop_count`  out  `CNT_W`  stop tokens accepted, current transaction.
- `tx_count`  out  16  completed transactions.
- `cycle_count`  out  `CNT_W`  cycles of current/last transaction.
- `max_stop_lvl`  out  8  highest stop level seen in current transaction.
- `proto_err`  out  1  sticky handshake/protocol violation.

## Operation
- Token classes:
  - data: `data[16]==0`.
  - stop: `data[16]==1`, `data[9:8]==2'b00`; level = `data[7:0]`.
  - done: `data[16]==1`, `data[9:8]==2'b01` (canonical 17'h10100).
  - Control with `data[9:8]` equal to 2'b10 or 2'b11 sets `proto_err`. The token is still accepted.
- Accept = `valid & ready`.
- States:
  - IDLE→ACTIVE on the first accept. The accepted token is counted, and `cycle_count` becomes 1.
  - ACTIVE: every accept updates the counters. An accepted done token increments `tx_count`.
    - If the new `tx_count == TX_NUM`: →DONE.
    - Else: →IDLE. `data_count`, `stop_count` and `max_stop_lvl` clear on the next accept in IDLE, not on the transition, so the outputs hold the last transaction's totals while idle.
  - DONE: `ready=0`, `done=1`. Any `valid` in DONE sets `proto_err`. Only flush or reset leaves DONE.
- `ready` = (state != DONE) & (~`bp_en` | `lfsr[1:0]` != 2'b00). This gives roughly 75% duty under backpressure. `ready` never depends on `valid`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle regardless of state.
- Handshake check: if the previous cycle had `valid & ~ready`, then this cycle must have `valid==1` and `data` unchanged. Otherwise set `proto_err`.
- `cycle_count` increments every cycle in ACTIVE, including stalled cycles, and freezes on leaving ACTIVE.
- All counters saturate at all-ones and do not wrap.
- `max_stop_lvl` = max over accepted stop-token levels.

## Timing
- Reset (async) and flush (sync) set every output and register as follows:
  - state = IDLE, all counters = 0, `proto_err`=0, `done`=0, LFSR=`LFSR_SEED`.
  - `ready` = 1 if `bp_en`=0; otherwise it follows seed bits [1:0] (1 for the default seed).
- Reset or flush mid-transaction discards the partial counts. The first token after release starts a fresh transaction.
- Flush has priority over a simultaneous accept; the token is dropped.
- Counter outputs are registered and reflect an accept one cycle after the accepting edge.
- `done` rises in the cycle after the final done-token accept.
- Zero-latency acceptance is allowed: back-to-back accepts every cycle when `bp_en`=0.
- Done and data in the same cycle is impossible (one token per cycle).
- A done token arriving in IDLE, i.e. an empty transaction, is counted as a full transaction with `cycle_count`=1.

## Structure
- Shared package `stream_token_pkg`:
  - `TOKEN_W`=17.
  - Control-type enum {STOP=0, DONE=1}.
  - `DONE_TOKEN`=17'h10100.
  - Decode functions `is_ctrl`, `is_stop`, `is_done`, `stop_lvl`.
  - State enum {IDLE, ACTIVE, DONE}.
- Sub-module `lfsr16` holds the seedable LFSR with flush reload. It is reused by the stream source.
- Everything else is in one module.

## Test plan
- `bp_en`=0, stream {5, 7, 17'h10000, 9, 17'h10001, 17'h10100}, `TX_NUM`=1 → `data_count`=3, `stop_count`=2, `max_stop_lvl`=1, `cycle_count`=6, `done`=1 after the final accept, `ready`=0 thereafter.
- `bp_en`=1, same stream with the source holding data while stalled → identical counts, `cycle_count` > 6 and equal to the number of ACTIVE cycles, `proto_err`=0; the `ready` pattern matches a reference LFSR model.
- Source drops `valid` (or changes `data` 3→4) while `ready`=0 → `proto_err`=1 next cycle and stays set until flush.
- `TX_NUM`=2: two transactions separated by 10 idle cycles → `tx_count`=1 after the first transaction, with counts held during the gap; the second transaction restarts the counts; `done` only after the second done token.
- Flush asserted mid-transaction after 3 tokens → all counters 0 and state IDLE; a following 2-token transaction reports `data_count`=1, `cycle_count`=2.
- Control token 17'h10200 accepted → `proto_err`=1 and counts unchanged; `valid` asserted in DONE → `proto_err`=1.
